// File: rtl/sprite_table.sv
// Sprite attribute table with a fixed-length scanline scan that streams
// up to MAX_PER_LINE intersecting sprites in ascending index order.
module sprite_table #(
    parameter int NUM_SPRITES  = 32,
    parameter int SPR_H        = 16,
    parameter int MAX_PER_LINE = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sprite_we,
    input  logic [4:0] sprite_sel,
    input  logic [9:0] sprite_x,
    input  logic [8:0] sprite_y,
    input  logic       sprite_vis,
    input  logic       sprite_attr,
    input  logic       sprite_pos,
    input  logic       scan_start,
    input  logic [8:0] scan_line,
    output logic       scan_busy,
    output logic       hit_valid,
    output logic [4:0] hit_index,
    output logic [9:0] hit_x,
    output logic [3:0] hit_row,
    output logic       hit_pos,
    output logic       scan_done,
    output logic       overflow
);
    localparam int CW = $clog2(MAX_PER_LINE + 1);

    typedef enum logic {IDLE, SCAN} state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic       vis;
        logic       attr;
        logic       pos;
    } entry_t;

    entry_t table_reg [NUM_SPRITES];

    state_t     state_reg, state_next;
    logic [4:0] idx_reg, idx_next;
    logic [CW-1:0] count_reg, count_next;
    logic [8:0] line_reg, line_next;
    logic       ovf_reg, ovf_next;
    logic       done_reg, done_next;
    logic       hv_reg;
    logic [4:0] hidx_reg;
    logic [9:0] hx_reg;
    logic [3:0] hrow_reg;
    logic       hpos_reg;

    entry_t     cur;
    logic [9:0] y_end;
    logic [8:0] diff;
    logic [3:0] row;
    logic       match;
    logic       emit;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                table_reg[i] <= '0;
            end
        end else if (sprite_we) begin
            table_reg[sprite_sel] <= entry_t'{x: sprite_x, y: sprite_y, vis: sprite_vis,
                                              attr: sprite_attr, pos: sprite_pos};
        end
    end

    // Intersection test; y_end is one bit wider so sprites near the bottom never wrap to the top.
    always_comb begin
        cur   = table_reg[idx_reg];
        y_end = {1'b0, cur.y} + 10'(SPR_H);
        diff  = line_reg - cur.y;
        match = cur.vis && (line_reg >= cur.y) && ({1'b0, line_reg} < y_end);
        row   = cur.attr ? (4'(SPR_H - 1) - diff[3:0]) : diff[3:0];
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        count_next = count_reg;
        line_next  = line_reg;
        ovf_next   = ovf_reg;
        done_next  = 1'b0;
        emit       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (scan_start) begin
                    state_next = SCAN;
                    line_next  = scan_line;
                    idx_next   = '0;
                    count_next = '0;
                    ovf_next   = 1'b0;
                end
            end
            SCAN: begin
                if (match) begin
                    if (count_reg < CW'(MAX_PER_LINE)) begin
                        emit       = 1'b1;
                        count_next = count_reg + 1'b1;
                    end else begin
                        ovf_next = 1'b1;
                    end
                end
                if (idx_reg == 5'(NUM_SPRITES - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            count_reg <= '0;
            line_reg  <= '0;
            ovf_reg   <= 1'b0;
            done_reg  <= 1'b0;
            hv_reg    <= 1'b0;
            hidx_reg  <= '0;
            hx_reg    <= '0;
            hrow_reg  <= '0;
            hpos_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            line_reg  <= line_next;
            ovf_reg   <= ovf_next;
            done_reg  <= done_next;
            hv_reg    <= emit;
            if (emit) begin
                hidx_reg <= idx_reg;
                hx_reg   <= cur.x;
                hrow_reg <= row;
                hpos_reg <= cur.pos;
            end
        end
    end

    assign scan_busy = (state_reg == SCAN);
    assign hit_valid = hv_reg;
    assign hit_index = hidx_reg;
    assign hit_x     = hx_reg;
    assign hit_row   = hrow_reg;
    assign hit_pos   = hpos_reg;
    assign scan_done = done_reg;
    assign overflow  = ovf_reg;
endmodule

// File: tb/tb_sprite_table.sv
// Bench for sprite_table: directed vector table, corner-case sequences and
// randomized scans checked cycle by cycle against a list-based scanline model.
module tb_sprite_table;
    logic       clk = 1'b0;
    logic       reset;
    logic       sprite_we;
    logic [4:0] sprite_sel;
    logic [9:0] sprite_x;
    logic [8:0] sprite_y;
    logic       sprite_vis, sprite_attr, sprite_pos;
    logic       scan_start;
    logic [8:0] scan_line;
    logic       scan_busy, hit_valid, hit_pos, scan_done, overflow;
    logic [4:0] hit_index;
    logic [9:0] hit_x;
    logic [3:0] hit_row;

    int vectors = 0;
    int miscompares = 0;

    // Model of the sprite table and of the held hit fields
    int t_x[32], t_y[32], t_vis[32], t_attr[32], t_pos[32];
    int m_idx = 0, m_x = 0, m_row = 0, m_pos = 0;

    always #5 clk = ~clk;

    sprite_table dut (
        .clk(clk), .reset(reset), .sprite_we(sprite_we), .sprite_sel(sprite_sel),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_vis(sprite_vis),
        .sprite_attr(sprite_attr), .sprite_pos(sprite_pos), .scan_start(scan_start),
        .scan_line(scan_line), .scan_busy(scan_busy), .hit_valid(hit_valid),
        .hit_index(hit_index), .hit_x(hit_x), .hit_row(hit_row), .hit_pos(hit_pos),
        .scan_done(scan_done), .overflow(overflow)
    );

    typedef struct {
        bit do_write;
        int sel, x, y, vis, attr, pos;
        bit do_scan;
        int line;
        int exp_hits, exp_idx0, exp_row0, exp_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin
            t_x[i] = 0; t_y[i] = 0; t_vis[i] = 0; t_attr[i] = 0; t_pos[i] = 0;
        end
        m_idx = 0; m_x = 0; m_row = 0; m_pos = 0;
    endtask

    task automatic drive_write(input int sel, input int x, input int y, input int vis,
                               input int attr, input int pos);
        sprite_we   = 1'b1;
        sprite_sel  = 5'(sel);
        sprite_x    = 10'(x);
        sprite_y    = 9'(y);
        sprite_vis  = vis[0];
        sprite_attr = attr[0];
        sprite_pos  = pos[0];
    endtask

    task automatic write_entry(input int sel, input int x, input int y, input int vis,
                               input int attr, input int pos);
        drive_write(sel, x, y, vis, attr, pos);
        tick();
        sprite_we = 1'b0;
        t_x[sel] = x; t_y[sel] = y; t_vis[sel] = vis; t_attr[sel] = attr; t_pos[sel] = pos;
    endtask

    // One full scan. Cycle 0 is the scan_start cycle; optional extra start pulse,
    // mid-scan write (ws,wx,...) and reset at given cycles (0 = none).
    task automatic run_scan(input int line, input int ign_cyc, input int wr_cyc,
                            input int ws, input int wx, input int wy, input int wv,
                            input int wa, input int wp, input int rst_cyc,
                            output int n_hits, output int idx0, output int row0,
                            output int ovf33);
        int sx[32], sy[32], sv[32], sa[32], sp[32];
        int hit_at[32];
        int listed, ovf_from, c, d;
        string tag;
        for (int i = 0; i < 32; i++) begin
            sx[i] = t_x[i]; sy[i] = t_y[i]; sv[i] = t_vis[i]; sa[i] = t_attr[i]; sp[i] = t_pos[i];
            hit_at[i] = -1;
        end
        // A write in cycle k is seen by entries evaluated after cycle k
        if (wr_cyc > 0 && ws >= wr_cyc) begin
            sx[ws] = wx; sy[ws] = wy; sv[ws] = wv; sa[ws] = wa; sp[ws] = wp;
        end
        listed = 0;
        ovf_from = 1000;
        for (int i = 0; i < 32; i++) begin
            if (sv[i] != 0 && line >= sy[i] && line < sy[i] + 16) begin
                if (listed < 4) begin
                    hit_at[i] = i + 2;
                    listed++;
                end else if (ovf_from == 1000) begin
                    ovf_from = i + 2;
                end
            end
        end
        if (rst_cyc > 0) begin
            for (int i = 0; i < 32; i++) if (hit_at[i] > rst_cyc) hit_at[i] = -1;
            if (ovf_from > rst_cyc) ovf_from = 1000;
        end
        n_hits = 0; idx0 = -1; row0 = -1; ovf33 = -1;
        for (c = 0; c <= 33; c++) begin
            if (c > 0) begin
                int e_hv;
                bit after_rst;
                after_rst = (rst_cyc > 0 && c > rst_cyc);
                e_hv = 0;
                for (int i = 0; i < 32; i++) begin
                    if (hit_at[i] == c) begin
                        e_hv = 1;
                        d = line - sy[i];
                        m_idx = i; m_x = sx[i]; m_pos = sp[i];
                        m_row = (sa[i] != 0) ? 15 - d : d;
                    end
                end
                if (after_rst && c == rst_cyc + 1) begin
                    m_idx = 0; m_x = 0; m_row = 0; m_pos = 0;
                end
                tag = $sformatf("line%0d c%0d", line, c);
                chk({tag, " busy"}, 32'(scan_busy), (!after_rst && c <= 32) ? 1 : 0);
                chk({tag, " done"}, 32'(scan_done), (!after_rst && c == 33) ? 1 : 0);
                chk({tag, " hit_valid"}, 32'(hit_valid), 32'(e_hv));
                chk({tag, " ovf"}, 32'(overflow), (!after_rst && c >= ovf_from) ? 1 : 0);
                chk({tag, " hit_index"}, 32'(hit_index), 32'(m_idx));
                chk({tag, " hit_x"}, 32'(hit_x), 32'(m_x));
                chk({tag, " hit_row"}, 32'(hit_row), 32'(m_row));
                chk({tag, " hit_pos"}, 32'(hit_pos), 32'(m_pos));
                if (hit_valid === 1'b1) begin
                    if (n_hits == 0) begin
                        idx0 = int'(hit_index);
                        row0 = int'(hit_row);
                    end
                    n_hits++;
                end
                if (c == 33) ovf33 = int'(overflow);
            end
            scan_start = (c == 0 || c == ign_cyc);
            scan_line  = (c == 0 || c == ign_cyc) ? 9'(line) : 9'($urandom_range(0, 511));
            reset      = (rst_cyc > 0 && c == rst_cyc);
            if (wr_cyc > 0 && c == wr_cyc) drive_write(ws, wx, wy, wv, wa, wp);
            else sprite_we = 1'b0;
            tick();
        end
        scan_start = 1'b0;
        sprite_we  = 1'b0;
        reset      = 1'b0;
        if (wr_cyc > 0) begin
            t_x[ws] = wx; t_y[ws] = wy; t_vis[ws] = wv; t_attr[ws] = wa; t_pos[ws] = wp;
        end
        if (rst_cyc > 0) clear_model();
    endtask

    vec_t vecs[13];

    initial begin
        int nh, i0, r0, ov;
        vecs[0]  = '{0, 0, 0,   0,   0, 0, 0, 1, 0,   0, -1, -1, 0};
        vecs[1]  = '{1, 7, 100, 40,  1, 0, 1, 1, 45,  1, 7, 5, 0};
        vecs[2]  = '{0, 0, 0,   0,   0, 0, 0, 1, 56,  0, -1, -1, 0};
        vecs[3]  = '{1, 3, 0,   10,  1, 1, 0, 1, 10,  1, 3, 15, 0};
        vecs[4]  = '{0, 0, 0,   0,   0, 0, 0, 1, 25,  1, 3, 0, 0};
        vecs[5]  = '{1, 2, 11,  100, 1, 0, 0, 0, 0,   0, 0, 0, 0};
        vecs[6]  = '{1, 5, 22,  100, 1, 0, 1, 0, 0,   0, 0, 0, 0};
        vecs[7]  = '{1, 9, 33,  100, 1, 1, 0, 0, 0,   0, 0, 0, 0};
        vecs[8]  = '{1, 12, 44, 100, 1, 0, 1, 0, 0,   0, 0, 0, 0};
        vecs[9]  = '{1, 20, 55, 100, 1, 0, 0, 0, 0,   0, 0, 0, 0};
        vecs[10] = '{1, 31, 66, 100, 1, 0, 0, 1, 100, 4, 2, 0, 1};
        vecs[11] = '{0, 0, 0,   0,   0, 0, 0, 1, 0,   0, -1, -1, 0};
        vecs[12] = '{1, 31, 77, 500, 1, 0, 0, 1, 3,   0, -1, -1, 0};

        reset = 1'b1; sprite_we = 1'b0; sprite_sel = '0; sprite_x = '0; sprite_y = '0;
        sprite_vis = 1'b0; sprite_attr = 1'b0; sprite_pos = 1'b0;
        scan_start = 1'b0; scan_line = '0;
        clear_model();
        tick(); tick();
        reset = 1'b0;
        chk("reset busy", 32'(scan_busy), 0);
        chk("reset hit_valid", 32'(hit_valid), 0);
        chk("reset done", 32'(scan_done), 0);
        chk("reset ovf", 32'(overflow), 0);
        chk("reset hit_fields", {hit_index, hit_x, hit_row, hit_pos}, 0);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].do_write)
                write_entry(vecs[v].sel, vecs[v].x, vecs[v].y, vecs[v].vis,
                            vecs[v].attr, vecs[v].pos);
            if (vecs[v].do_scan) begin
                run_scan(vecs[v].line, 0, 0, 0, 0, 0, 0, 0, 0, 0, nh, i0, r0, ov);
                chk($sformatf("vec%0d hits", v), 32'(nh), 32'(vecs[v].exp_hits));
                chk($sformatf("vec%0d idx0", v), 32'(i0), 32'(vecs[v].exp_idx0));
                chk($sformatf("vec%0d row0", v), 32'(r0), 32'(vecs[v].exp_row0));
                chk($sformatf("vec%0d ovf", v), 32'(ov), 32'(vecs[v].exp_ovf));
            end
        end

        // Invisible sprite exactly on the line
        write_entry(4, 0, 3, 0, 0, 0);
        run_scan(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, nh, i0, r0, ov);
        chk("invisible hits", 32'(nh), 0);

        // Extra scan_start in cycle 10 is ignored; 5 sprites on line 100 overflow
        run_scan(100, 10, 0, 0, 0, 0, 0, 0, 0, 0, nh, i0, r0, ov);
        chk("ignored start hits", 32'(nh), 4);
        chk("ignored start ovf", 32'(ov), 1);

        // Write to entry 0 while it is evaluated: old contents win
        write_entry(0, 321, 200, 1, 0, 1);
        run_scan(200, 0, 1, 0, 5, 0, 0, 0, 0, 0, nh, i0, r0, ov);
        chk("same-cycle write hits", 32'(nh), 1);
        chk("same-cycle write idx", 32'(i0), 0);

        // Reset mid-scan (cycle 15), then everything must read as cleared
        run_scan(100, 0, 0, 0, 0, 0, 0, 0, 0, 15, nh, i0, r0, ov);
        chk("reset mid-scan hits", 32'(nh), 4);
        run_scan(100, 0, 0, 0, 0, 0, 0, 0, 0, 0, nh, i0, r0, ov);
        chk("cleared table hits", 32'(nh), 0);

        for (int it = 0; it < 30; it++) begin
            int wc, ic;
            for (int k = 0; k < 6; k++) begin
                int yy;
                yy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(490, 511))
                                                 : int'($urandom_range(0, 40));
                write_entry($urandom_range(0, 31), $urandom_range(0, 1023), yy,
                            ($urandom_range(0, 4) != 0) ? 1 : 0, $urandom_range(0, 1),
                            $urandom_range(0, 1));
            end
            wc = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 32)) : 0;
            ic = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 32)) : 0;
            run_scan($urandom_range(0, 60), ic, wc, $urandom_range(0, 31),
                     $urandom_range(0, 1023), $urandom_range(0, 50), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), 0, nh, i0, r0, ov);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sprite_table.md
Name: sprite_table

Overview:
- Receiving end of the sprite-register write path driven by the execute stage's sprite instruction outputs (sprite_sel, sprite_x, sprite_y, sprite_vis, sprite_attr, sprite_pos).
- Stores one attribute entry per sprite.
- On request from the VGA line renderer, typically at hblank start, scans every entry and streams up to MAX_PER_LINE sprites that intersect the requested scanline, in ascending index order.

Parameters:
NUM_SPRITES, 32, number of entries; index width is 5 bits, fixed.
SPR_H, 16, sprite height in lines; power of two, 4-bit row output.
MAX_PER_LINE, 4, maximum hits emitted per scan.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high; clears table and FSM.
sprite_we  in  1  write strobe for one table entry.
sprite_sel  in  5  entry index to write.
sprite_x  in  10  sprite left X.
sprite_y  in  9  sprite top Y.
sprite_vis  in  1  entry visible.
sprite_attr  in  1  vertical flip.
sprite_pos  in  1  priority: 1 = in front of background.
scan_start  in  1  single-cycle scan request.
scan_line  in  9  scanline to evaluate; sampled with scan_start.
scan_busy  out  1  scan in progress.
hit_valid  out  1  hit_* fields valid this cycle.
hit_index  out  5  index of hit sprite.
hit_x  out  10  X of hit sprite.
hit_row  out  4  row within sprite to fetch.
hit_pos  out  1  priority of hit sprite.
scan_done  out  1  one-cycle pulse at scan completion.
overflow  out  1  more than MAX_PER_LINE sprites on the last scanned line.

Behaviour:
- Reset:
  - All entries: x=0, y=0, vis=0, attr=0, pos=0.
  - FSM goes to IDLE.
  - scan_busy, hit_valid, scan_done and overflow = 0.
  - hit_index, hit_x, hit_row and hit_pos = 0.
  - Reset asserted mid-scan aborts the scan; no further hits and no scan_done.
- Table write: when sprite_we=1, entry[sprite_sel] is loaded with all five fields at the rising edge. The new values are visible to a scan from the next cycle. sprite_we is accepted in every state.
- FSM states: IDLE, SCAN.
  - IDLE -> SCAN when scan_start=1. Latch scan_line, set idx=0, set count=0, clear overflow.
  - scan_start while in SCAN is ignored.
- Timing, with scan_start high in cycle 0:
  - State is SCAN in cycles 1..32; scan_busy=1 in those cycles.
  - Entry i is evaluated combinationally in cycle i+1 against the registered table.
  - A hit for entry i is presented registered in cycle i+2.
  - After idx=NUM_SPRITES-1, the FSM returns to IDLE. scan_done=1 in cycle 33 only.
  - A new scan_start is accepted in cycle 33.
- Hit condition:
  - vis=1, line >= y, and line < y+SPR_H.
  - y+SPR_H is computed 10 bits wide: no wrap, so a sprite at y=500 never matches line 3.
  - d = (line - y)[3:0].
  - hit_row = d when attr=0; hit_row = SPR_H-1-d when attr=1.
- Limit:
  - On a hit with count < MAX_PER_LINE: hit_valid pulses for one cycle and count increments.
  - On a hit with count = MAX_PER_LINE: no hit_valid; overflow is set.
  - Scanning continues over all entries regardless of the limit.
  - overflow stays set until the next accepted scan_start or reset.
- hit_valid is 0 in any cycle without an emitted hit. hit_* fields hold their last values when hit_valid=0.
- Write and scan in the same cycle on the entry currently being evaluated: evaluation uses the old contents.
- A scan always takes exactly 32 cycles, independent of hit count.

Test Plan:
- Reset, then scan line 0 -> no hit_valid in cycles 2..33; scan_done only in cycle 33; overflow=0; scan_busy high in cycles 1..32.
- Write entry 7 with x=100, y=40, vis=1, attr=0, pos=1. Scan line 45 -> one hit in cycle 9: index=7, x=100, row=5, pos=1. Scan line 56 -> no hit (y+16=56 is excluded).
- Vertical flip: entry 3 with y=10, attr=1. Scan line 10 -> row=15. Scan line 25 -> row=0.
- Entries 2, 5, 9, 12, 20, 31 all with y=100, vis=1. Scan line 100 -> hits 2, 5, 9, 12 in cycles 4, 7, 11, 14; overflow=1 by cycle 33. Next scan of line 0 -> overflow cleared at start.
- Entry 31 with y=500, vis=1. Scan line 3 -> no hit. Then entry 4 with vis=0 and y=3: scan line 3 -> no hit.
- Boundary timing:
  - scan_start pulsed in cycle 10 of an active scan -> ignored; scan_done still in cycle 33.
  - Write entry 0 in cycle 1 of a scan -> old data used.
  - Reset in cycle 15 -> hit_valid and scan_done stay 0; table cleared; scan_busy=0 next cycle.
